// File: rtl/fir_tap_loader.sv
// Host-side FIR tap source: coefficient RAM plus reload/stream sequencer.
// Define FIR_TAP_LOADER_TIMEOUT_EN to add the STREAM/WAIT_DONE watchdog.
module fir_tap_loader #(
   parameter int G_NUM_TAPS_LOG2  = 4,
   parameter int G_TAP_WIDTH      = 16,
   parameter int G_FLUSH_CYCLES   = 2,
   parameter int G_TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [G_NUM_TAPS_LOG2-1:0] coef_wr_addr,
   input  logic [G_TAP_WIDTH-1:0]     coef_wr_data,
   input  logic                       coef_wr_en,
   output logic                       coef_wr_ready,
   input  logic                       load_start,
   output logic                       busy,
   output logic                       load_done,
   output logic                       load_err,
   output logic                       err_sticky,
   output logic                       fir_enable,
   output logic [G_TAP_WIDTH-1:0]     tap_dout,
   output logic                       tap_dout_valid,
   input  logic                       tap_dout_ready,
   input  logic                       tap_dout_done
);

   localparam int N     = G_NUM_TAPS_LOG2;
   localparam int DEPTH = 1 << N;
   localparam int FC_W  = $clog2(G_FLUSH_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_ARM, S_STREAM, S_WAIT, S_ERR
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [G_TAP_WIDTH-1:0] r_ram [DEPTH];
   logic [G_TAP_WIDTH-1:0] r_ram_q;
   logic [G_TAP_WIDTH-1:0] r_dout;
   logic                   r_dout_vld;
   logic                   r_fir_en;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;
   logic                   r_sticky;
   logic [N-1:0]           r_rd_ptr;
   logic [N-1:0]           r_idx;
   logic                   r_all_issued;
   logic [FC_W-1:0]        r_flush_cnt;

   logic         w_xfer;
   logic         w_last;
   logic         w_load;
   logic         w_wr;
   logic         w_flush_end;
   logic         w_timeout;
   logic [N-1:0] w_rd_addr;

   assign w_xfer      = r_dout_vld & tap_dout_ready;
   assign w_last      = w_xfer & (r_idx == '1);
   assign w_load      = (r_state == S_STREAM) & ~r_all_issued
                        & (~r_dout_vld | tap_dout_ready);
   assign w_wr        = coef_wr_en & (r_state == S_IDLE) & reset_n;
   assign w_flush_end = (r_flush_cnt == FC_W'(G_FLUSH_CYCLES - 1));

   // Read address runs one ahead of the output register so r_ram_q is always the next tap
   always_comb begin
      w_rd_addr = r_rd_ptr;
      if (r_state == S_ARM) begin
         w_rd_addr = '0;
      end else if (w_load) begin
         w_rd_addr = r_rd_ptr + 1'b1;
      end
   end

`ifdef FIR_TAP_LOADER_TIMEOUT_EN
   localparam int TO_W = $clog2(G_TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_to_cnt <= '0;
      end else if (r_state == S_ARM || w_xfer) begin
         r_to_cnt <= '0;
      end else if (r_state == S_STREAM || r_state == S_WAIT) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == S_STREAM || r_state == S_WAIT)
                      && (r_to_cnt == TO_W'(G_TIMEOUT_CYCLES - 1));
`else
   // Watchdog compiled out
   assign w_timeout = 1'b0 && (G_TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (load_start) w_state_nxt = S_FLUSH;
         S_FLUSH:  if (w_flush_end) w_state_nxt = S_ARM;
         S_ARM:    w_state_nxt = S_STREAM;
         S_STREAM: begin
            if (w_last) begin
               w_state_nxt = S_WAIT;
            end else if (tap_dout_done || w_timeout) begin
               w_state_nxt = S_ERR;
            end
         end
         S_WAIT: begin
            if (tap_dout_done) begin
               w_state_nxt = S_IDLE;
            end else if (w_timeout) begin
               w_state_nxt = S_ERR;
            end
         end
         S_ERR:    w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_ram[coef_wr_addr] <= coef_wr_data;
      end
      r_ram_q <= r_ram[w_rd_addr];
   end

   // Outputs are registered from the next state so they line up with r_state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_dout       <= '0;
         r_dout_vld   <= 1'b0;
         r_fir_en     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_sticky     <= 1'b0;
         r_rd_ptr     <= '0;
         r_idx        <= '0;
         r_all_issued <= 1'b0;
         r_flush_cnt  <= '0;
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= (r_state == S_WAIT) && (w_state_nxt == S_IDLE);
         r_err  <= (w_state_nxt == S_ERR);

         if (r_state == S_IDLE && load_start) begin
            r_sticky <= 1'b0;
         end else if (w_state_nxt == S_ERR) begin
            r_sticky <= 1'b1;
         end

         if (w_state_nxt == S_FLUSH || w_state_nxt == S_ERR) begin
            r_fir_en <= 1'b0;
         end else if (w_state_nxt == S_ARM) begin
            r_fir_en <= 1'b1;
         end

         if (r_state == S_FLUSH) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end else begin
            r_flush_cnt <= '0;
         end

         if (r_state == S_ARM) begin
            r_rd_ptr     <= '0;
            r_idx        <= '0;
            r_all_issued <= 1'b0;
         end

         if (w_load) begin
            r_dout     <= r_ram_q;
            r_dout_vld <= 1'b1;
            if (r_rd_ptr == '1) begin
               r_all_issued <= 1'b1;
            end else begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end else if (w_xfer) begin
            r_dout_vld <= 1'b0;
         end

         if (w_xfer && r_idx != '1) begin
            r_idx <= r_idx + 1'b1;
         end

         if (w_state_nxt != S_STREAM) begin
            r_dout_vld <= 1'b0;
         end
      end
   end

   assign coef_wr_ready  = ~r_busy;
   assign busy           = r_busy;
   assign load_done      = r_done;
   assign load_err       = r_err;
   assign err_sticky     = r_sticky;
   assign fir_enable     = r_fir_en;
   assign tap_dout       = r_dout;
   assign tap_dout_valid = r_dout_vld;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader: reset, streaming, back-pressure,
// busy-time commands, early done, mid-stream reset, optional watchdog.
module tb_fir_tap_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  coef_wr_addr;
   logic [15:0] coef_wr_data;
   logic        coef_wr_en;
   logic        coef_wr_ready;
   logic        load_start;
   logic        busy;
   logic        load_done;
   logic        load_err;
   logic        err_sticky;
   logic        fir_enable;
   logic [15:0] tap_dout;
   logic        tap_dout_valid;
   logic        tap_dout_ready;
   logic        tap_dout_done;

   always #5 clk = ~clk;

   fir_tap_loader #(
      .G_NUM_TAPS_LOG2  (4),
      .G_TAP_WIDTH      (16),
      .G_FLUSH_CYCLES   (2),
      .G_TIMEOUT_CYCLES (32)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .coef_wr_addr   (coef_wr_addr),
      .coef_wr_data   (coef_wr_data),
      .coef_wr_en     (coef_wr_en),
      .coef_wr_ready  (coef_wr_ready),
      .load_start     (load_start),
      .busy           (busy),
      .load_done      (load_done),
      .load_err       (load_err),
      .err_sticky     (err_sticky),
      .fir_enable     (fir_enable),
      .tap_dout       (tap_dout),
      .tap_dout_valid (tap_dout_valid),
      .tap_dout_ready (tap_dout_ready),
      .tap_dout_done  (tap_dout_done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] got [16];
   int n, nd, ne, unst, extra, flo, c_first, c_last, c_err;

   task automatic write_taps();
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         coef_wr_en   = 1'b1;
         coef_wr_addr = 4'(k);
         coef_wr_data = 16'(k + 1);
      end
      @(negedge clk);
      coef_wr_en = 1'b0;
   endtask

   // rmode: 0 ready high, 1 toggling, 2 held low
   // poke: 1 busy-time start+write, 2 write addr 0 on the start cycle
   task automatic stream(input int rmode, input int done_at,
                         input int rst_at, input int poke);
      logic        pv, pr;
      logic [15:0] pd;
      n = 0; nd = 0; ne = 0; unst = 0; extra = 0; flo = 0;
      c_first = -1; c_last = -1; c_err = -1;
      pv = 1'b0; pr = 1'b0; pd = '0;
      for (int i = 0; i < 16; i++) got[i] = '0;
      @(negedge clk);
      load_start     = 1'b1;
      tap_dout_done  = 1'b0;
      tap_dout_ready = 1'b0;
      if (poke == 2) begin
         coef_wr_en   = 1'b1;
         coef_wr_addr = 4'd0;
         coef_wr_data = 16'h8001;
      end
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (pv && !pr && !(tap_dout_valid === 1'b1 && tap_dout === pd))
            unst++;
         if (load_done === 1'b1) nd++;
         if (load_err === 1'b1) begin
            ne++;
            if (c_err < 0) c_err = c;
         end
         if (busy === 1'b1 && fir_enable === 1'b0) flo++;
         if (busy !== 1'b1) break;
         load_start = 1'b0;
         coef_wr_en = 1'b0;
         if (poke == 1 && c == 6) begin
            load_start   = 1'b1;
            coef_wr_en   = 1'b1;
            coef_wr_addr = 4'd3;
            coef_wr_data = 16'hBEEF;
         end
         if (n >= done_at) tap_dout_done = 1'b1;
         case (rmode)
            0:       tap_dout_ready = 1'b1;
            1:       tap_dout_ready = c[0];
            default: tap_dout_ready = 1'b0;
         endcase
         if (tap_dout_done) tap_dout_ready = 1'b0;
         if (rst_at > 0 && n == rst_at) begin
            reset_n        = 1'b0;
            tap_dout_ready = 1'b0;
         end
         if (tap_dout_valid === 1'b1 && tap_dout_ready) begin
            if (n < 16) got[n] = tap_dout;
            else extra++;
            if (c_first < 0) c_first = c;
            c_last = c;
            n++;
         end
         pv = tap_dout_valid;
         pr = tap_dout_ready;
         pd = tap_dout;
      end
      load_start = 1'b0;
      coef_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, fir_enable, tap_dout_valid, load_done, load_err, err_sticky} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags got %b want 000000",
                  {busy, fir_enable, tap_dout_valid, load_done, load_err, err_sticky});
      end
      n_cmp++;
      if (tap_dout !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_dout got %h want 0000", tap_dout);
      end
      n_cmp++;
      if (coef_wr_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_wr_ready got %b want 1", coef_wr_ready);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      stream(0, 16, 0, 0);
      n_cmp++;
      if (n !== 16) begin
         n_bad++;
         $display("FAIL t1_count got %0d want 16", n);
      end
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (got[k] !== 16'(k + 1)) begin
            n_bad++;
            $display("FAIL t1_tap%0d got %h want %h", k, got[k], 16'(k + 1));
         end
      end
      n_cmp++;
      if (c_last - c_first !== 15) begin
         n_bad++;
         $display("FAIL t1_span got %0d want 15", c_last - c_first);
      end
      n_cmp++;
      if (nd !== 1 || ne !== 0 || extra !== 0) begin
         n_bad++;
         $display("FAIL t1_pulses got done=%0d err=%0d extra=%0d want 1/0/0", nd, ne, extra);
      end
      n_cmp++;
      if (flo !== 2) begin
         n_bad++;
         $display("FAIL t1_flush got %0d want 2", flo);
      end
      n_cmp++;
      if (busy !== 1'b0 || fir_enable !== 1'b1 || err_sticky !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_end got busy=%b en=%b sticky=%b want 0/1/0",
                  busy, fir_enable, err_sticky);
      end
   endtask

   task automatic test_ready_toggle();
      stream(1, 16, 0, 0);
      n_cmp++;
      if (n !== 16 || extra !== 0) begin
         n_bad++;
         $display("FAIL t2_count got %0d extra=%0d want 16 extra=0", n, extra);
      end
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (got[k] !== 16'(k + 1)) begin
            n_bad++;
            $display("FAIL t2_tap%0d got %h want %h", k, got[k], 16'(k + 1));
         end
      end
      n_cmp++;
      if (unst !== 0) begin
         n_bad++;
         $display("FAIL t2_stable got %0d unstable cycles want 0", unst);
      end
      n_cmp++;
      if (nd !== 1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL t2_done got done=%0d busy=%b want 1/0", nd, busy);
      end
   endtask

   task automatic test_busy_ignore();
      stream(0, 16, 0, 1);
      n_cmp++;
      if (n !== 16 || nd !== 1 || got[3] !== 16'h0004) begin
         n_bad++;
         $display("FAIL t3_stream got n=%0d done=%0d tap3=%h want 16/1/0004",
                  n, nd, got[3]);
      end
      stream(0, 16, 0, 2);
      n_cmp++;
      if (got[3] !== 16'h0004) begin
         n_bad++;
         $display("FAIL t3_ram_kept got %h want 0004", got[3]);
      end
      n_cmp++;
      if (got[0] !== 16'h8001) begin
         n_bad++;
         $display("FAIL t3_start_write got %h want 8001", got[0]);
      end
      n_cmp++;
      if (n !== 16 || nd !== 1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL t3_reload got n=%0d done=%0d busy=%b want 16/1/0", n, nd, busy);
      end
   endtask

   task automatic test_early_done();
      stream(0, 5, 0, 0);
      n_cmp++;
      if (n !== 5 || ne !== 1 || nd !== 0) begin
         n_bad++;
         $display("FAIL t4_err got n=%0d err=%0d done=%0d want 5/1/0", n, ne, nd);
      end
      n_cmp++;
      if ({err_sticky, fir_enable, tap_dout_valid, load_err, busy} !== 5'b10000) begin
         n_bad++;
         $display("FAIL t4_state got %b want 10000",
                  {err_sticky, fir_enable, tap_dout_valid, load_err, busy});
      end
      stream(0, 16, 0, 0);
      n_cmp++;
      if (err_sticky !== 1'b0 || nd !== 1 || n !== 16) begin
         n_bad++;
         $display("FAIL t4_recover got sticky=%b done=%0d n=%0d want 0/1/16",
                  err_sticky, nd, n);
      end
   endtask

   task automatic test_reset_abort();
      stream(0, 16, 8, 0);
      n_cmp++;
      if (n !== 8) begin
         n_bad++;
         $display("FAIL t5_count got %0d want 8", n);
      end
      n_cmp++;
      if ({busy, fir_enable, tap_dout_valid, load_done, load_err, err_sticky} !== 6'b0
          || tap_dout !== 16'h0 || coef_wr_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL t5_reset got flags=%b dout=%h rdy=%b want 000000/0000/1",
                  {busy, fir_enable, tap_dout_valid, load_done, load_err, err_sticky},
                  tap_dout, coef_wr_ready);
      end
      reset_n = 1'b1;
      stream(0, 16, 0, 0);
      n_cmp++;
      if (n !== 16 || nd !== 1 || got[0] !== 16'h8001 || got[15] !== 16'h0010) begin
         n_bad++;
         $display("FAIL t5_reload got n=%0d done=%0d t0=%h t15=%h want 16/1/8001/0010",
                  n, nd, got[0], got[15]);
      end
   endtask

`ifdef FIR_TAP_LOADER_TIMEOUT_EN
   task automatic test_timeout();
      stream(2, 16, 0, 0);
      n_cmp++;
      if (ne !== 1 || c_err !== 35 || n !== 0) begin
         n_bad++;
         $display("FAIL t6_timeout got err=%0d at=%0d n=%0d want 1/35/0", ne, c_err, n);
      end
      n_cmp++;
      if (err_sticky !== 1'b1 || fir_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_state got sticky=%b en=%b want 1/0", err_sticky, fir_enable);
      end
   endtask
`endif

   initial begin
      reset_n        = 1'b0;
      coef_wr_addr   = '0;
      coef_wr_data   = '0;
      coef_wr_en     = 1'b0;
      load_start     = 1'b0;
      tap_dout_ready = 1'b0;
      tap_dout_done  = 1'b0;
      test_reset();
      write_taps();
      test_back_to_back();
      test_ready_toggle();
      test_busy_ignore();
      test_early_done();
      test_reset_abort();
`ifdef FIR_TAP_LOADER_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
